// File: rtl/mod_arith_pkg.sv
// Shared types and helpers for the limb-serial modular arithmetic blocks.
package mod_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for up to 256 limbs per operand.
  localparam int unsigned IDX_W = 8;

  function automatic int unsigned calc_nl(input int unsigned width, input int unsigned limb);
    return width / limb;
  endfunction

endpackage

// File: rtl/limb_addsub.sv
// Combinational W-bit add or subtract with carry/borrow in and out; zero latency, no flow control.
// In subtract mode c_o is the borrow out.
module limb_addsub #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic [W:0] res;

  // The extra top bit is the carry for add and the borrow for subtract.
  always_comb begin
    res = '0;
    if (sub_i) res = {1'b0, x_i} - {1'b0, y_i} - {{W{1'b0}}, c_i};
    else       res = {1'b0, x_i} + {1'b0, y_i} + {{W{1'b0}}, c_i};
  end

  assign s_o = res[W-1:0];
  assign c_o = res[W];

endmodule

// File: rtl/mod_addsub_serial.sv
// Limb-serial (a +/- b) mod P: one limb per cycle, result held in DONE until out_ready,
// giving one operation per NL+2 cycles; operands are only taken in IDLE.
module mod_addsub_serial
  import mod_arith_pkg::*;
#(
  parameter int unsigned      WIDTH = 128,
  parameter int unsigned      LIMB  = 32,
  parameter logic [WIDTH-1:0] P     = 128'd37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             range_err
);

  localparam int unsigned      NL       = calc_nl(WIDTH, LIMB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NL - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             c1_q, c2_q, sub_q, err_q, range_err_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, t_q, r_q;

  logic [LIMB-1:0]  a_k, b_k, p_k, s_k, t_k;
  logic             c1_d, c2_d, take_t;
  logic [WIDTH-1:0] s_d, t_d;

  assign a_k = a_q[idx_q*LIMB +: LIMB];
  assign b_k = b_q[idx_q*LIMB +: LIMB];
  assign p_k = P[idx_q*LIMB +: LIMB];

  limb_addsub #(.W(LIMB)) u_path1 (
    .x_i  (a_k),
    .y_i  (b_k),
    .sub_i(sub_q),
    .c_i  (c1_q),
    .s_o  (s_k),
    .c_o  (c1_d)
  );

  // Path 2 corrects path 1 by P in the opposite direction.
  limb_addsub #(.W(LIMB)) u_path2 (
    .x_i  (s_k),
    .y_i  (p_k),
    .sub_i(~sub_q),
    .c_i  (c2_q),
    .s_o  (t_k),
    .c_o  (c2_d)
  );

  always_comb begin
    s_d = s_q;
    t_d = t_q;
    s_d[idx_q*LIMB +: LIMB] = s_k;
    t_d[idx_q*LIMB +: LIMB] = t_k;
    // Add: sum overflowed or sum >= P. Sub: a < b, so P must be added back.
    take_t = sub_q ? c1_d : (c1_d | ~c2_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      sub_q       <= 1'b0;
      err_q       <= 1'b0;
      range_err_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      t_q         <= '0;
      r_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            err_q   <= (a >= P) || (b >= P);
            idx_q   <= '0;
            c1_q    <= 1'b0;
            c2_q    <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q   <= s_d;
          t_q   <= t_d;
          c1_q  <= c1_d;
          c2_q  <= c2_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            r_q         <= take_t ? t_d : s_d;
            range_err_q <= err_q;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign r         = r_q;
  assign range_err = range_err_q;

endmodule
